seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller for the AHB_SEG_KEY peripheral. It drives NUM_DIGITS common-anode digits from a packed per-digit {dp, hex} word. Beyond plain scanning, it adds per-digit enable, blinking, leading-zero suppression, PWM brightness and anti-ghosting dead time. All logic runs on HCLK with a single-cycle scan tick, so no derived scan clock exists. It sits between the AHB register slave, which supplies DATA and the control fields, and the board pins.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_scan_timer.sv | 82 ++++++++
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  // Per-digit field layout inside the packed DATA word: {dp, hex[3:0]}
  localparam int unsigned DIGIT_W = 5;
  localparam int unsigned HEX_W   = 4;
  localparam int unsigned DP_BIT  = 4;
  localparam int unsigned SEG_W   = 7;

  typedef logic [SEG_W-1:0] seg_t;

  typedef struct packed {
    logic             dp;
    logic [HEX_W-1:0] hex;
  } digit_t;

  // All segments off
  localparam seg_t SEG_BLANK = 7'h00;

  // Hex digit to {g..a} segment pattern, active-high
  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [HEX_W-1:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing: slot prescaler, digit index, blink phase and PWM ramp.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_DIV    = 28673,
  parameter int unsigned BRIGHT_W    = 4,
  parameter int unsigned BLINK_TICKS = 512
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  output logic [$clog2(SCAN_DIV)-1:0]   pcnt,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          tick_c,
  output logic                          frame_start_c,
  output logic                          phase,
  output logic [BRIGHT_W-1:0]           pwm
);

  localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned BCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BCNT_W-1:0] bcnt;

  // Slot end and frame end strobes
  always_comb begin
    tick_c        = (pcnt == PCNT_W'(SCAN_DIV - 1));
    frame_start_c = tick_c && (idx == IDX_W'(NUM_DIGITS - 1));
  end

  // Prescaler: one slot is SCAN_DIV cycles
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pcnt <= '0;
    end else if (tick_c) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Digit index advances once per slot
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx <= '0;
    end else if (tick_c) begin
      if (idx == IDX_W'(NUM_DIGITS - 1)) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Blink half-period counter, measured in slots
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (tick_c) begin
      if (bcnt == BCNT_W'(BLINK_TICKS - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BCNT_W'(1);
      end
    end
  end

  // PWM ramp restarts at every slot boundary so each slot sees the same duty pattern
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pwm <= '0;
    end else if (tick_c) begin
      pwm <= '0;
    end else begin
      pwm <= pwm + BRIGHT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment controller with enable, blink,
// leading-zero suppression, PWM brightness and dead time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_DIV    = 28673,
  parameter int unsigned BRIGHT_W    = 4,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned BLINK_TICKS = 512
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] DATA,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          lz_suppress,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [SEG_W-1:0]              seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp
);

  localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = DIGIT_W * NUM_DIGITS;

  logic [PCNT_W-1:0]     pcnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick_c;
  logic                  frame_start_c;
  logic                  phase;
  logic [BRIGHT_W-1:0]   pwm;

  logic                  first_q;
  logic [DATA_W-1:0]     data_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic                  lz_q;
  logic [BRIGHT_W-1:0]   bright_q;

  logic [NUM_DIGITS-1:0] supp_c;
  logic                  zero_run_c;
  digit_t                cur_c;
  logic                  blank_c;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BRIGHT_W    (BRIGHT_W),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_timer (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .pcnt          (pcnt),
    .idx           (idx),
    .tick_c        (tick_c),
    .frame_start_c (frame_start_c),
    .phase         (phase),
    .pwm           (pwm)
  );

  // Marks the first clock after reset release so shadows load immediately
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
    end
  end

  // Shadow registers change only at frame boundaries to avoid tearing
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_q   <= '0;
      en_q     <= '0;
      blink_q  <= '0;
      lz_q     <= 1'b0;
      bright_q <= '0;
    end else if (first_q || frame_start_c) begin
      data_q   <= DATA;
      en_q     <= digit_en;
      blink_q  <= blink_mask;
      lz_q     <= lz_suppress;
      bright_q <= brightness;
    end
  end

  // Leading-zero run from the top digit down; digit 0 always shows
  always_comb begin
    int unsigned i;
    supp_c     = '0;
    zero_run_c = lz_q;
    i          = 0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      i          = NUM_DIGITS - 1 - j;
      zero_run_c = zero_run_c && (data_q[i*DIGIT_W +: DIGIT_W] == '0);
      supp_c[i]  = zero_run_c && (i != 0);
    end
  end

  // Blank decision for the digit currently in its slot
  always_comb begin
    cur_c   = digit_t'(data_q[DIGIT_W*32'(idx) +: DIGIT_W]);
    blank_c = (pcnt < PCNT_W'(DEAD_CYCLES))
           || !en_q[idx]
           || (blink_q[idx] && phase)
           || supp_c[idx]
           || ((bright_q != '1) && (pwm >= bright_q));
  end

  // Registered pin drive
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
    end else if (blank_c) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= hex_to_seg(cur_c.hex);
      dp  <= cur_c.dp;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl against a per-cycle arithmetic model.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 32;
  localparam int BW = 4;
  localparam int DC = 2;
  localparam int BT = 4;
  localparam int FRAME = ND * SD;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [5*ND-1:0]   DATA = '0;
  logic [ND-1:0]     digit_en = '0;
  logic [ND-1:0]     blink_mask = '0;
  logic              lz_suppress = 1'b0;
  logic [BW-1:0]     brightness = '0;
  logic [6:0]        seg;
  logic [ND-1:0]     an;
  logic              dp;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BRIGHT_W    (BW),
    .DEAD_CYCLES (DC),
    .BLINK_TICKS (BT)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .DATA        (DATA),
    .digit_en    (digit_en),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .dp          (dp)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: cycles since reset release plus the frame-latched inputs
  int              m_cyc = 0;
  logic [5*ND-1:0] s_data = '0;
  logic [ND-1:0]   s_en = '0;
  logic [ND-1:0]   s_blink = '0;
  logic            s_lz = 1'b0;
  logic [BW-1:0]   s_br = '0;

  function automatic exp_t model_out(input int c);
    exp_t e;
    int pcnt, slot, di, ph, pwm, top_nz;
    logic [4:0] d;
    logic blank;
    pcnt = c % SD;
    slot = c / SD;
    di   = slot % ND;
    ph   = (slot / BT) % 2;
    pwm  = pcnt % (1 << BW);
    top_nz = -1;
    for (int j = 0; j < ND; j++)
      if (s_data[5*j +: 5] != 5'd0) top_nz = j;
    d = s_data[5*di +: 5];
    blank = (pcnt < DC) || !s_en[di] || (s_blink[di] && ph == 1)
         || (s_lz && di > top_nz && di != 0)
         || (s_br != 4'hF && pwm >= int'(s_br));
    if (blank) begin
      e.an = '1; e.seg = 7'h00; e.dp = 1'b0;
    end else begin
      e.an = ~(ND'(1) << di); e.seg = dec[d[3:0]]; e.dp = d[4];
    end
    return e;
  endfunction

  // Reference model: one expected output per clock edge
  always @(posedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      m_cyc = 0;
      s_data = '0; s_en = '0; s_blink = '0; s_lz = 1'b0; s_br = '0;
      e.an = '1; e.seg = 7'h00; e.dp = 1'b0;
      q.push_back(e);
    end else begin
      q.push_back(model_out(m_cyc));
      if (m_cyc == 0 || (m_cyc % FRAME) == FRAME - 1) begin
        s_data = DATA; s_en = digit_en; s_blink = blink_mask;
        s_lz = lz_suppress; s_br = brightness;
      end
      m_cyc++;
    end
  end

  // Monitor: compare DUT pins against the oldest expectation
  always @(negedge HCLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if ({an, seg, dp} !== e) begin
        n_err++;
        $display("FAIL scan t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic wait_pos(input int di, input int p);
    bit hit;
    hit = 0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge HCLK);
      if ((m_cyc / SD) % ND == di && m_cyc % SD == p) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      n_vec++; n_err++;
      $display("FAIL wait_pos digit=%0d pcnt=%0d not reached", di, p);
    end
  endtask

  task automatic check_first_lit(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge HCLK);
      if (an !== '1) begin
        k = i;
        break;
      end
    end
    n_vec++;
    if (k != 3) begin
      n_err++;
      $display("FAIL %s first lit at cycle %0d, expected 3", name, k);
    end
  endtask

  task automatic set_in(input logic [5*ND-1:0] d, input logic [ND-1:0] en,
                        input logic [ND-1:0] bl, input logic lz, input logic [BW-1:0] br);
    DATA = d; digit_en = en; blink_mask = bl; lz_suppress = lz; brightness = br;
  endtask

  initial begin
    int lit;
    // Basic scan, lit from reset release
    set_in({5'h13, 5'h02, 5'h01, 5'h10}, 4'hF, 4'h0, 1'b0, 4'hF);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    check_first_lit("reset_release");
    repeat (2 * FRAME) @(negedge HCLK);

    // Leading-zero suppression
    set_in({5'h00, 5'h00, 5'h05, 5'h00}, 4'hF, 4'h0, 1'b1, 4'hF);
    repeat (3 * FRAME) @(negedge HCLK);

    // Blink on digit 0
    set_in({5'h13, 5'h02, 5'h01, 5'h10}, 4'hF, 4'b0001, 1'b0, 4'hF);
    repeat (6 * FRAME) @(negedge HCLK);

    // Brightness 4, then 0
    set_in({5'h13, 5'h02, 5'h01, 5'h10}, 4'hF, 4'h0, 1'b0, 4'h4);
    repeat (2 * FRAME) @(negedge HCLK);
    brightness = 4'h0;
    wait_pos(0, 0);
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge HCLK);
      if (an !== '1) lit++;
    end
    n_vec++;
    if (lit != 0) begin
      n_err++;
      $display("FAIL bright0 lit cycles=%0d expected 0", lit);
    end

    // Mid-frame DATA change must wait for the next frame boundary
    set_in({5'h13, 5'h02, 5'h01, 5'h10}, 4'hF, 4'h0, 1'b0, 4'hF);
    wait_pos(1, 10);
    DATA = {5'h0E, 5'h1A, 5'h07, 5'h09};
    repeat (2 * FRAME) @(negedge HCLK);

    // Asynchronous reset in the middle of digit 2
    wait_pos(2, 12);
    #1 HRESETn = 1'b0;
    #1;
    n_vec++;
    if (an !== 4'hF || seg !== 7'h00 || dp !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset an=%h seg=%h dp=%b expected an=f seg=00 dp=0", an, seg, dp);
    end
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    check_first_lit("reset_mid_scan");

    // Randomized inputs applied at random points
    for (int it = 0; it < 40; it++) begin
      @(negedge HCLK);
      set_in(($urandom_range(0, 3) == 0) ? '0 : (5*ND)'($urandom),
             ND'($urandom), ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0,
             1'($urandom), ($urandom_range(0, 1) == 0) ? 4'hF : BW'($urandom));
      repeat ($urandom_range(1, 200)) @(negedge HCLK);
    end

    repeat (3) @(negedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
